// File: rtl/spi_slave_frontend_if.sv
// SPI pins plus the RAM command/response handshake of the SPI slave front end.
interface spi_slave_frontend_if #(
  parameter int unsigned ADDR_CMD_W = 10,
  parameter int unsigned DATA_W     = 8
);
  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [ADDR_CMD_W-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: deserialises MOSI frames into RAM command words and
// serialises the RAM read response onto MISO for read-data frames.
module spi_slave_frontend #(
  parameter int unsigned ADDR_CMD_W = 10,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_frontend_if.slave   bus
);

  localparam int unsigned BCNT_W = $clog2(ADDR_CMD_W + 1);
  localparam int unsigned TCNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_CMD_W-2:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ADDR_CMD_W-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rd_addr_seen_q, rd_addr_seen_d;
  logic                    miso_q, miso_d;
  logic [DATA_W-2:0]       tx_shift_q, tx_shift_d;
  logic [TCNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic                    wait_tx_q, wait_tx_d;
  logic [ADDR_CMD_W-1:0]   word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      miso_q         <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      wait_tx_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      miso_q         <= miso_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      wait_tx_q      <= wait_tx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    miso_d         = miso_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    wait_tx_d      = wait_tx_q;
    word           = {shift_q, bus.MOSI};

    if (bus.SS_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      tx_cnt_d  = '0;
      wait_tx_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
        end
        CHK_CMD: begin
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                    state_d = READ_ADD;
        end
        default: begin
          // Only the top ADDR_CMD_W-1 bits are stored; the last bit joins at completion.
          if (bit_cnt_q != BCNT_W'(ADDR_CMD_W)) begin
            shift_d   = word[ADDR_CMD_W-2:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCNT_W'(ADDR_CMD_W - 1)) begin
              rx_data_d  = word;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
              if (state_q == READ_DATA) begin
                rd_addr_seen_d = 1'b0;
                wait_tx_d      = 1'b1;
              end
            end
          end
          if (state_q == READ_DATA) begin
            if (wait_tx_q && bus.tx_valid) begin
              miso_d     = bus.tx_data[DATA_W-1];
              tx_shift_d = bus.tx_data[DATA_W-2:0];
              tx_cnt_d   = TCNT_W'(DATA_W - 1);
              wait_tx_d  = 1'b0;
            end else if (tx_cnt_q != '0) begin
              miso_d     = tx_shift_q[DATA_W-2];
              tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
              tx_cnt_d   = tx_cnt_q - 1'b1;
            end else begin
              miso_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: a vector table for whole frames plus
// hand-written sequences for aborts and resets.
module tb_spi_slave_frontend;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_frontend_if #(.ADDR_CMD_W(10), .DATA_W(8)) bus ();

  spi_slave_frontend #(.ADDR_CMD_W(10), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       rst, ss_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       exp_miso, exp_rxv;
    logic       chk_rx;
    logic [9:0] exp_rx;
    logic       chk_seen, exp_seen;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, s, m, tv, input logic [7:0] td,
                     input logic miso, rxv, input logic crx, input logic [9:0] rx,
                     input logic cs, es);
    vec_t v;
    v.rst = r; v.ss_n = s; v.mosi = m; v.tx_valid = tv; v.tx_data = td;
    v.exp_miso = miso; v.exp_rxv = rxv; v.chk_rx = crx; v.exp_rx = rx;
    v.chk_seen = cs; v.exp_seen = es;
    vecs.push_back(v);
  endtask

  // E0, command bit, then ten payload bits; completion expected after the last.
  task automatic add_frame(input logic cmd, input logic [9:0] w, input logic tv,
                           input logic [7:0] td, input logic es);
    add(0, 0, 0, tv, td, 0, 0, 0, '0, 0, 0);
    add(0, 0, cmd, tv, td, 0, 0, 0, '0, 0, 0);
    for (int i = 9; i >= 1; i--) add(0, 0, w[i], tv, td, 0, 0, 0, '0, 0, 0);
    add(0, 0, w[0], tv, td, 0, 1, 1, w, 1, es);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, s, m, tv, input logic [7:0] td);
    rst = r; bus.SS_n = s; bus.MOSI = m; bus.tx_valid = tv; bus.tx_data = td;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic cmd, input logic [9:0] w);
    cyc(0, 0, 0, 0, 8'h00);
    chk("frm_e0_rxv", 32'(bus.rx_valid), 0);
    cyc(0, 0, cmd, 0, 8'h00);
    for (int i = 9; i >= 1; i--) begin
      cyc(0, 0, w[i], 0, 8'h00);
      chk("frm_bit_rxv", 32'(bus.rx_valid), 0);
    end
    cyc(0, 0, w[0], 0, 8'h00);
    chk("frm_done_rxv", 32'(bus.rx_valid), 1);
    chk("frm_done_rx", 32'(bus.rx_data), 32'(w));
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1; bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;

    // reset state
    add(1, 1, 0, 0, 8'h00, 0, 0, 1, 10'h000, 1, 0);
    add(1, 1, 0, 0, 8'h00, 0, 0, 1, 10'h000, 1, 0);
    // write frame with spurious tx_valid throughout
    add_frame(0, 10'h0A5, 1, 8'hFF, 0);
    add(0, 0, 1, 1, 8'hFF, 0, 0, 1, 10'h0A5, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 1, 10'h0A5, 1, 0);
    // read address
    add_frame(1, 10'h23C, 0, 8'h00, 1);
    add(0, 1, 0, 0, 8'h00, 0, 0, 1, 10'h23C, 1, 1);
    // read data, immediate tx_valid, tx_valid held during serialization
    add_frame(1, 10'h300, 0, 8'h00, 0);
    pat = 8'hB6;
    add(0, 0, 0, 1, pat, pat[7], 0, 0, '0, 0, 0);
    for (int i = 6; i >= 0; i--) add(0, 0, 0, 1, 8'h00, pat[i], 0, 0, '0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0, '0, 0, 0);
    add(0, 0, 0, 1, 8'hFF, 0, 0, 0, '0, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 1, 10'h300, 1, 0);
    // read address then read data with tx_valid 4 cycles late
    add_frame(1, 10'h155, 0, 8'h00, 1);
    add(0, 1, 0, 0, 8'h00, 0, 0, 0, '0, 1, 1);
    add_frame(1, 10'h2AA, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 8'h00, 0, 0, 0, '0, 0, 0);
    pat = 8'h81;
    add(0, 0, 0, 1, pat, pat[7], 0, 0, '0, 0, 0);
    for (int i = 6; i >= 0; i--) add(0, 0, 0, 0, 8'h00, pat[i], 0, 0, '0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0, '0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 1, 10'h2AA, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].ss_n, vecs[i].mosi, vecs[i].tx_valid, vecs[i].tx_data);
      chk($sformatf("vec%0d_miso", i), 32'(bus.MISO), 32'(vecs[i].exp_miso));
      chk($sformatf("vec%0d_rxv", i), 32'(bus.rx_valid), 32'(vecs[i].exp_rxv));
      if (vecs[i].chk_rx)
        chk($sformatf("vec%0d_rx", i), 32'(bus.rx_data), 32'(vecs[i].exp_rx));
      if (vecs[i].chk_seen)
        chk($sformatf("vec%0d_seen", i), 32'(dut.rd_addr_seen_q), 32'(vecs[i].exp_seen));
    end

    // aborted READ_ADD after 5 payload bits
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 8'h00);
      chk("abort_rxv", 32'(bus.rx_valid), 0);
    end
    cyc(0, 1, 1, 0, 8'h00);
    chk("abort_rxv_end", 32'(bus.rx_valid), 0);
    chk("abort_rx_hold", 32'(bus.rx_data), 32'h2AA);
    chk("abort_seen", 32'(dut.rd_addr_seen_q), 0);
    run_frame(1, 10'h0F0);
    cyc(0, 0, 0, 1, 8'hAA);
    chk("after_abort_no_resp", 32'(bus.MISO), 0);
    chk("after_abort_seen", 32'(dut.rd_addr_seen_q), 1);
    cyc(0, 1, 0, 0, 8'h00);

    // SS_n rising mid-response aborts MISO
    run_frame(1, 10'h111);
    cyc(0, 0, 0, 1, 8'hFF);
    chk("ssabort_b7", 32'(bus.MISO), 1);
    cyc(0, 0, 0, 0, 8'h00);
    chk("ssabort_b6", 32'(bus.MISO), 1);
    cyc(0, 1, 0, 0, 8'h00);
    chk("ssabort_miso", 32'(bus.MISO), 0);
    cyc(0, 1, 0, 0, 8'h00);
    chk("ssabort_miso_idle", 32'(bus.MISO), 0);

    // reset during the 3rd MISO bit
    run_frame(1, 10'h222);
    cyc(0, 1, 0, 0, 8'h00);
    run_frame(1, 10'h333);
    cyc(0, 0, 0, 1, 8'hB6);
    chk("rstresp_b7", 32'(bus.MISO), 1);
    cyc(0, 0, 0, 0, 8'h00);
    chk("rstresp_b6", 32'(bus.MISO), 0);
    cyc(0, 0, 0, 0, 8'h00);
    chk("rstresp_b5", 32'(bus.MISO), 1);
    cyc(1, 0, 0, 0, 8'h00);
    chk("rstresp_miso", 32'(bus.MISO), 0);
    chk("rstresp_seen", 32'(dut.rd_addr_seen_q), 0);
    chk("rstresp_rx", 32'(bus.rx_data), 0);
    cyc(0, 1, 0, 0, 8'h00);
    run_frame(1, 10'h044);
    chk("post_rst_seen", 32'(dut.rd_addr_seen_q), 1);
    cyc(0, 1, 0, 0, 8'h00);

    // reset mid-frame clears a set read-address flag
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(1, 0, 1, 0, 8'h00);
    chk("rstframe_seen", 32'(dut.rd_addr_seen_q), 0);
    chk("rstframe_rxv", 32'(bus.rx_valid), 0);
    cyc(0, 1, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
